// File: rtl/aes_inv_round_ops.sv
// Inverse AES round datapath: InvShiftRows, AddRoundKey, optional InvMixColumns.
// An acceptance register samples data/key/last_round, so the block leaves three edges after the load edge.
module aes_inv_round_ops (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [127:0] data,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] result,
  output logic         oready,
  output logic         iready
);

  function automatic logic [7:0] gf_x2(input logic [7:0] a);
    gf_x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = gf_x2(a[i]);
      x4[i] = gf_x2(x2[i]);
      x8[i] = gf_x2(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
    for (int c = 0; c < 4; c++) begin
      inv_mix_columns[127-32*c -: 32] = inv_mix_col(st[127-32*c -: 32]);
    end
  endfunction

  // Row r rotates right by r: destination column c takes source column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        inv_shift_rows[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  endfunction

  logic         accept_s;
  logic         in_v_q, in_v_d;
  logic [127:0] in_data_q, in_data_d;
  logic [127:0] in_key_q, in_key_d;
  logic         in_last_q, in_last_d;
  logic         s1_v_q, s1_v_d;
  logic [127:0] s1_q, s1_d;
  logic [127:0] s1_key_q, s1_key_d;
  logic         s1_last_q, s1_last_d;
  logic         s2_v_q, s2_v_d;
  logic [127:0] s2_q, s2_d;
  logic         s2_last_q, s2_last_d;
  logic         s3_v_q, s3_v_d;
  logic [127:0] s3_q, s3_d;

  assign iready   = ~reset_n;
  assign accept_s = load & ~reset_n;
  assign result   = s3_q;
  assign oready   = s3_v_q;

  // Next-state for every pipeline stage; data registers hold when their feeding stage is empty.
  always_comb begin
    in_v_d    = accept_s;
    in_data_d = in_data_q;
    in_key_d  = in_key_q;
    in_last_d = in_last_q;
    s1_v_d    = in_v_q;
    s1_d      = s1_q;
    s1_key_d  = s1_key_q;
    s1_last_d = s1_last_q;
    s2_v_d    = s1_v_q;
    s2_d      = s2_q;
    s2_last_d = s2_last_q;
    s3_v_d    = s2_v_q;
    s3_d      = s3_q;
    if (accept_s) begin
      in_data_d = data;
      in_key_d  = round_key;
      in_last_d = last_round;
    end else begin
      in_data_d = in_data_q;
    end
    if (in_v_q) begin
      s1_d      = inv_shift_rows(in_data_q);
      s1_key_d  = in_key_q;
      s1_last_d = in_last_q;
    end else begin
      s1_d = s1_q;
    end
    if (s1_v_q) begin
      s2_d      = s1_q ^ s1_key_q;
      s2_last_d = s1_last_q;
    end else begin
      s2_d = s2_q;
    end
    if (s2_v_q) begin
      s3_d = s2_last_q ? s2_q : inv_mix_columns(s2_q);
    end else begin
      s3_d = s3_q;
    end
  end

  // Pipeline registers with synchronous active-high reset that flushes all in-flight blocks.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      in_v_q    <= 1'b0;
      in_data_q <= 128'h0;
      in_key_q  <= 128'h0;
      in_last_q <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_q      <= 128'h0;
      s1_key_q  <= 128'h0;
      s1_last_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_q      <= 128'h0;
      s2_last_q <= 1'b0;
      s3_v_q    <= 1'b0;
      s3_q      <= 128'h0;
    end else begin
      in_v_q    <= in_v_d;
      in_data_q <= in_data_d;
      in_key_q  <= in_key_d;
      in_last_q <= in_last_d;
      s1_v_q    <= s1_v_d;
      s1_q      <= s1_d;
      s1_key_q  <= s1_key_d;
      s1_last_q <= s1_last_d;
      s2_v_q    <= s2_v_d;
      s2_q      <= s2_d;
      s2_last_q <= s2_last_d;
      s3_v_q    <= s3_v_d;
      s3_q      <= s3_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ops.sv
// Scoreboard bench for aes_inv_round_ops: expected blocks are queued at acceptance and
// popped when oready fires, with the exit edge checked against a 3-edge latency.
module tb_aes_inv_round_ops;
  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         load = 1'b0;
  logic [127:0] data = 128'h0;
  logic [127:0] round_key = 128'h0;
  logic         last_round = 1'b0;
  logic [127:0] result;
  logic         oready;
  logic         iready;

  typedef struct {
    logic [127:0] res;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] pending_exp = 128'h0;
  logic [127:0] last_res = 128'h0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           armed = 1'b0;

  aes_inv_round_ops dut (
    .clk(clk), .reset_n(reset_n), .load(load), .data(data), .round_key(round_key),
    .last_round(last_round), .result(result), .oready(oready), .iready(iready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic lr);
    logic [127:0] st;
    logic [127:0] o;
    logic [7:0]   base [4];
    logic [7:0]   acc;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[127-8*(4*c+r) -: 8] = d[127-8*(4*((c-r+4)%4)+r) -: 8];
    st = st ^ k;
    if (lr) return st;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(base[(j-r+4)%4], st[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic put(input logic ld, input logic [127:0] d, input logic [127:0] k,
                     input logic lr, input logic [127:0] e);
    @(negedge clk);
    load = ld; data = d; round_key = k; last_round = lr; pending_exp = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, rnd128(), rnd128(), 1'($urandom_range(0, 1)), 128'h0);
  endtask

  task automatic put_rand();
    logic [127:0] d;
    logic [127:0] k;
    logic         lr;
    d = rnd128(); k = rnd128(); lr = 1'($urandom_range(0, 1));
    put(1'b1, d, k, lr, model(d, k, lr));
  endtask

  // Scoreboard: push on acceptance, check outputs 1 time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_n) sb_q.delete();
      else if (load) sb_q.push_back('{res: pending_exp, due: cyc + 3});
      #1;
      if (reset_n) begin
        armed = 1'b1;
        check_eq("rst_result", result, 128'h0);
        check_eq("rst_oready", 128'(oready), 128'h0);
        check_eq("rst_iready", 128'(iready), 128'h0);
        last_res = 128'h0;
      end else if (armed) begin
        check_eq("iready", 128'(iready), 128'h1);
        if (oready) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_oready", 128'h1, 128'h0);
          end else begin
            e = sb_q.pop_front();
            check_eq("result", result, e.res);
            check_eq("latency", 128'(cyc), 128'(e.due));
          end
          last_res = result;
        end else begin
          check_eq("hold", result, last_res);
          if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            check_eq("missing_oready", 128'h0, 128'h1);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [127:0] v25, v26;
    v25 = {4{32'h8e4da1bc}};
    v26 = 128'h000102030405060708090a0b0c0d0e0f;
    idle(3);
    put(1'b1, rnd128(), rnd128(), 1'b0, 128'h0);   // load during reset must be ignored
    put(1'b1, v25, 128'h0, 1'b0, {4{32'hdb135345}});
    reset_n = 1'b0;                                 // first non-reset edge accepts this load
    idle(4);
    put(1'b1, v26, 128'h0, 1'b1, 128'h000d0a0704010e0b0805020f0c090603);
    idle(4);
    put(1'b1, 128'h0, {128{1'b1}}, 1'b1, {128{1'b1}});
    idle(4);
    put(1'b1, 128'h0, {128{1'b1}}, 1'b0, {128{1'b1}});
    idle(4);
    put(1'b1, {4{32'h01010101}}, 128'h0, 1'b0, {4{32'h01010101}});
    idle(4);
    put(1'b1, {4{32'hc6c6c6c6}}, 128'h0, 1'b0, {4{32'hc6c6c6c6}});
    idle(4);
    // back-to-back loads; keys change every cycle afterwards
    put(1'b1, v25, 128'h0, 1'b0, {4{32'hdb135345}});
    put(1'b1, v26, 128'h0, 1'b1, 128'h000d0a0704010e0b0805020f0c090603);
    put(1'b1, 128'h0, {128{1'b1}}, 1'b0, {128{1'b1}});
    idle(5);
    for (int i = 0; i < 16; i++) begin
      put_rand();
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(5);
    // reset one edge after a load: that block must never emerge
    put_rand();
    put(1'b0, rnd128(), rnd128(), 1'b0, 128'h0);
    reset_n = 1'b1;
    put(1'b0, rnd128(), rnd128(), 1'b0, 128'h0);
    reset_n = 1'b0;
    idle(6);
    put_rand();
    put_rand();
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() == 0) break;
      idle(1);
    end
    check_eq("drain", 128'(sb_q.size()), 128'h0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
